wb_regfile: RTL

//  Write-back end of the MEM/WB pipeline interface: consumes the MEM/WB register outputs,

---
 rtl/wb_pkg.sv | 14 +
 rtl/wb_regfile_if.sv | 34 +++
 rtl/wb_regfile_wb_sel.sv | 24 ++
 rtl/wb_regfile.sv | 68 ++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared constants and types for the MEM/WB write-back slice.
package wb_pkg;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned CNT_W = 32;
  localparam int unsigned NREG  = 2 ** AW;

  typedef logic [AW-1:0] reg_addr_t;
  typedef logic [DW-1:0] word_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB-to-regfile bus: pipeline inputs, ID read ports and write-back taps.
interface wb_regfile_if #(
  parameter int unsigned DW    = wb_pkg::DW,
  parameter int unsigned AW    = wb_pkg::AW,
  parameter int unsigned CNT_W = wb_pkg::CNT_W
);

  logic             wb_en;
  logic [AW-1:0]    in_RegDst;
  logic [DW-1:0]    in_ALUResult;
  logic [DW-1:0]    in_RDMem;
  logic             in_cRegWrite;
  logic             in_cMemtoReg;
  logic [AW-1:0]    rs_addr;
  logic [AW-1:0]    rt_addr;
  logic [DW-1:0]    rs_data;
  logic [DW-1:0]    rt_data;
  logic [DW-1:0]    wb_data;
  logic             wb_we;
  logic [CNT_W-1:0] wr_count;

  modport master (
    output wb_en, in_RegDst, in_ALUResult, in_RDMem, in_cRegWrite, in_cMemtoReg,
    output rs_addr, rt_addr,
    input  rs_data, rt_data, wb_data, wb_we, wr_count
  );

  modport slave (
    input  wb_en, in_RegDst, in_ALUResult, in_RDMem, in_cRegWrite, in_cMemtoReg,
    input  rs_addr, rt_addr,
    output rs_data, rt_data, wb_data, wb_we, wr_count
  );

endinterface

// File: rtl/wb_regfile_wb_sel.sv
// Write-back data mux (load vs ALU) and effective write-strobe qualification.
module wb_sel
  import wb_pkg::*;
#(
  parameter int unsigned DW = wb_pkg::DW,
  parameter int unsigned AW = wb_pkg::AW
) (
  input  logic          i_wb_en,
  input  logic [AW-1:0] i_reg_dst,
  input  logic [DW-1:0] i_alu_result,
  input  logic [DW-1:0] i_rd_mem,
  input  logic          i_reg_write,
  input  logic          i_mem_to_reg,
  output logic [DW-1:0] o_wb_data,
  output logic          o_wb_we
);

  always_comb begin
    o_wb_data = i_mem_to_reg ? i_rd_mem : i_alu_result;
    // r0 is hardwired to zero, so a write aimed at it is not a commit
    o_wb_we   = i_wb_en & i_reg_write & (i_reg_dst != AW'(REG_ZERO));
  end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: commits MEM/WB results into the GPR file and serves ID reads.
// Define WB_BYPASS_EN to forward the in-flight write-back value to the read ports.
module wb_regfile
  import wb_pkg::*;
#(
  parameter int unsigned DW    = wb_pkg::DW,
  parameter int unsigned AW    = wb_pkg::AW,
  parameter int unsigned CNT_W = wb_pkg::CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  wb_regfile_if.slave  bus
);

  localparam int unsigned NR = 2 ** AW;

  logic [DW-1:0]    r_gpr [NR];
  logic [CNT_W-1:0] r_wr_count;
  logic [DW-1:0]    w_wb_data;
  logic             w_wb_we;
  logic [DW-1:0]    w_rs_data;
  logic [DW-1:0]    w_rt_data;

  wb_sel #(
    .DW (DW),
    .AW (AW)
  ) u_wb_sel (
    .i_wb_en      (bus.wb_en),
    .i_reg_dst    (bus.in_RegDst),
    .i_alu_result (bus.in_ALUResult),
    .i_rd_mem     (bus.in_RDMem),
    .i_reg_write  (bus.in_cRegWrite),
    .i_mem_to_reg (bus.in_cMemtoReg),
    .o_wb_data    (w_wb_data),
    .o_wb_we      (w_wb_we)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NR; i++) begin
        r_gpr[i] <= '0;
      end
      r_wr_count <= '0;
    end else if (w_wb_we) begin
      r_gpr[bus.in_RegDst] <= w_wb_data;
      r_wr_count           <= r_wr_count + CNT_W'(1);
    end
  end

  always_comb begin
    w_rs_data = r_gpr[bus.rs_addr];
    w_rt_data = r_gpr[bus.rt_addr];
`ifdef WB_BYPASS_EN
    if (w_wb_we && (bus.rs_addr == bus.in_RegDst)) w_rs_data = w_wb_data;
    if (w_wb_we && (bus.rt_addr == bus.in_RegDst)) w_rt_data = w_wb_data;
`endif
    // zero gating on rst keeps reads at 0 even if bypass inputs are not yet quiet
    if (rst || (bus.rs_addr == AW'(REG_ZERO))) w_rs_data = '0;
    if (rst || (bus.rt_addr == AW'(REG_ZERO))) w_rt_data = '0;
  end

  assign bus.rs_data  = w_rs_data;
  assign bus.rt_data  = w_rt_data;
  assign bus.wb_data  = w_wb_data;
  assign bus.wb_we    = w_wb_we;
  assign bus.wr_count = r_wr_count;

endmodule
